// File: rtl/xgmii_axis_tx_framer.sv
// xgmii_axis_tx_framer: AXI-stream to SDR XGMII TX framer with preamble, terminate,
// min-IFG enforcement, underrun abort and frame/underrun counters.
module xgmii_axis_tx_framer #(
  parameter int DATA_W  = 64,
  parameter int MIN_IFG = 12,
  parameter int CNT_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [DATA_W-1:0]   s_axis_tdata,
  input  logic [DATA_W/8-1:0] s_axis_tkeep,
  input  logic                s_axis_tvalid,
  input  logic                s_axis_tlast,
  output logic                s_axis_tready,
  output logic [DATA_W-1:0]   xgmii_txd,
  output logic [DATA_W/8-1:0] xgmii_txc,
  output logic                busy,
  output logic [CNT_W-1:0]    frame_cnt,
  output logic [CNT_W-1:0]    underrun_cnt
);
  localparam int BYTES = DATA_W / 8;
  localparam logic [63:0] PREAMBLE = 64'hD555_5555_5555_55FB;
  localparam logic [DATA_W-1:0] IDLE_D = {BYTES{8'h07}};
  localparam logic [DATA_W-1:0] TERM_D = {{(BYTES-1){8'h07}}, 8'hFD};
  localparam logic [DATA_W-1:0] ERR_D = {BYTES{8'hFE}};

  typedef enum logic [2:0] {IDLE, PRE, DATA, TERM, ABORT, DROP, IFG} state_t;

  state_t              r_state, w_state;
  logic                r_pre, w_pre;
  logic [DATA_W-1:0]   r_txd, w_txd;
  logic [BYTES-1:0]    r_txc, w_txc;
  logic [6:0]          r_ifg, w_ifg;
  logic [CNT_W-1:0]    r_frame_cnt, r_underrun_cnt;
  logic                w_frame_inc, w_under_inc;
  logic [3:0]          w_k;
  logic [DATA_W-1:0]   w_term_d;
  logic [BYTES-1:0]    w_term_c;
  logic [6:0]          w_ifg_add, w_ifg_term;
  logic                w_pre_last;

  // k = length of the contiguous run of kept lanes starting at lane0
  always_comb begin
    w_k = 4'(BYTES);
    for (int i = BYTES - 1; i >= 0; i--)
      if (!s_axis_tkeep[i]) w_k = 4'(i);
  end

  always_comb begin
    w_term_d = IDLE_D;
    w_term_c = '1;
    for (int i = 0; i < BYTES; i++) begin
      w_term_d[8*i +: 8] = (4'(i) < w_k) ? s_axis_tdata[8*i +: 8] : (4'(i) == w_k) ? 8'hFD : 8'h07;
      w_term_c[i] = 4'(i) >= w_k;
    end
  end

  // IFG bytes on the wire so far, counted from /T/ inclusive up to the current output beat
  assign w_ifg_add  = (r_ifg > 7'(64 - BYTES)) ? 7'd64 : r_ifg + 7'(BYTES);
  assign w_ifg_term = 7'(BYTES) - 7'(w_k);
  assign w_pre_last = (BYTES == 8) || r_pre;

  always_comb begin
    w_state       = r_state;
    w_pre         = r_pre;
    w_txd         = IDLE_D;
    w_txc         = '1;
    w_ifg         = w_ifg_add;
    w_frame_inc   = 1'b0;
    w_under_inc   = 1'b0;
    s_axis_tready = 1'b0;
    case (r_state)
      IDLE: if (enable && s_axis_tvalid && r_ifg >= 7'(MIN_IFG)) begin
        w_state = PRE;
        w_pre   = 1'b0;
        w_txd   = DATA_W'(PREAMBLE);
        w_txc   = BYTES'(1);
        w_ifg   = r_ifg;
      end
      PRE, DATA: if (!w_pre_last) begin
        w_txd = DATA_W'(PREAMBLE >> 32);
        w_txc = '0;
        w_pre = 1'b1;
        w_ifg = r_ifg;
      end else begin
        s_axis_tready = 1'b1;
        if (!s_axis_tvalid) begin
          w_txd       = ERR_D;
          w_under_inc = 1'b1;
          w_state     = ABORT;
        end else if (!s_axis_tlast || w_k == 4'(BYTES)) begin
          w_txd   = s_axis_tdata;
          w_txc   = '0;
          w_state = s_axis_tlast ? TERM : DATA;
        end else begin
          w_txd       = w_term_d;
          w_txc       = w_term_c;
          w_frame_inc = 1'b1;
          w_ifg       = w_ifg_term;
          w_state     = (w_ifg_term >= 7'(MIN_IFG)) ? IDLE : IFG;
        end
      end
      TERM: begin
        w_txd       = TERM_D;
        w_frame_inc = 1'b1;
        w_ifg       = 7'(BYTES);
        w_state     = (7'(BYTES) >= 7'(MIN_IFG)) ? IDLE : IFG;
      end
      ABORT: begin
        w_txd   = TERM_D;
        w_ifg   = 7'(BYTES);
        w_state = DROP;
      end
      DROP: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) w_state = (w_ifg_add >= 7'(MIN_IFG)) ? IDLE : IFG;
      end
      IFG: if (w_ifg_add >= 7'(MIN_IFG)) w_state = IDLE;
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_pre          <= 1'b0;
      r_txd          <= IDLE_D;
      r_txc          <= '1;
      r_ifg          <= 7'd64;
      r_frame_cnt    <= '0;
      r_underrun_cnt <= '0;
    end else begin
      r_state        <= w_state;
      r_pre          <= w_pre;
      r_txd          <= w_txd;
      r_txc          <= w_txc;
      r_ifg          <= w_ifg;
      r_frame_cnt    <= r_frame_cnt + CNT_W'(w_frame_inc);
      r_underrun_cnt <= r_underrun_cnt + CNT_W'(w_under_inc);
    end
  end

  assign xgmii_txd    = r_txd;
  assign xgmii_txc    = r_txc;
  assign busy         = r_state != IDLE;
  assign frame_cnt    = r_frame_cnt;
  assign underrun_cnt = r_underrun_cnt;
endmodule
